eth_link_pulse: RTL and testbench

Parametrised 10BASE-T link-pulse generator, successor to the fixed-rate normal-link-pulse (NLP) generator. Emits either single NLPs or IEEE 802.3 clause 28 fast-link-pulse (FLP) bursts that carry a 16-bit link code word, at a fixed period. Pulses are deferred while a frame is being transmitted. Sits beside `eth_tx` in `top`; its `link` output is ORed onto the TX pair driver.

---
 rtl/eth_link_pkg.sv | 22 ++
 rtl/eth_pulse_gen.sv | 30 +++
 rtl/eth_link_pulse.sv | 123 ++++++++++++
 tb/tb_eth_link_pulse.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_link_pkg.sv
// Shared types and default 40 MHz timing for the 10BASE-T link-pulse generator.
package eth_link_pkg;

    typedef enum logic {
        LINK_NLP = 1'b0,
        LINK_FLP = 1'b1
    } link_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } link_state_t;

    localparam int unsigned FLP_SLOTS      = 33;
    localparam int unsigned SLOT_W         = 6;
    localparam int unsigned LCW_W          = 16;
    localparam int unsigned DEF_PULSE_CYC  = 4;
    localparam int unsigned DEF_PERIOD_CYC = 640000;
    localparam int unsigned DEF_SLOT_CYC   = 2500;

endpackage

// File: rtl/eth_pulse_gen.sv
// One-shot: on trig, holds pulse at en for PULSE_CYC cycles, then returns low.
module eth_pulse_gen #(
    parameter int unsigned PULSE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic en,
    output logic pulse
);

    localparam int unsigned CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (trig) begin
            cnt   <= CW'(PULSE_CYC - 1);
            pulse <= en;
        end else if (cnt != '0) begin
            cnt   <= cnt - CW'(1);
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_link_pulse.sv
// Periodic NLP / FLP-burst generator with frame deferral; slot sequencer and
// period timer live here, pulse shaping lives in eth_pulse_gen.
module eth_link_pulse
    import eth_link_pkg::*;
#(
    parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned SLOT_CYC   = DEF_SLOT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [LCW_W-1:0] lcw,
    input  logic             tx_busy,
    output logic             link,
    output logic             active,
    output logic             done
);

    localparam int unsigned PW = $clog2(PERIOD_CYC);
    localparam int unsigned SW = $clog2(SLOT_CYC);

    link_state_t       state_q, state_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    link_mode_t        mode_q, mode_d;
    logic [LCW_W-1:0]  lcw_q, lcw_d;
    logic              active_d, done_d;
    logic              trig_c, en_c, last_slot_c;
    logic [SLOT_W-1:0] slot_nx_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pcnt_q  <= PW'(PERIOD_CYC - 1);
            slot_q  <= '0;
            scnt_q  <= '0;
            mode_q  <= LINK_NLP;
            lcw_q   <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            slot_q  <= slot_d;
            scnt_q  <= scnt_d;
            mode_q  <= mode_d;
            lcw_q   <= lcw_d;
            active  <= active_d;
            done    <= done_d;
        end
    end

    // Next-state: period timer in IDLE, slot/pulse timing while an event runs.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q + PW'(1);
        slot_d      = slot_q;
        scnt_d      = scnt_q + SW'(1);
        mode_d      = mode_q;
        lcw_d       = lcw_q;
        active_d    = active;
        done_d      = 1'b0;
        trig_c      = 1'b0;
        en_c        = 1'b0;
        slot_nx_c   = slot_q + SLOT_W'(1);
        last_slot_c = (mode_q == LINK_NLP) ? (slot_q == '0)
                                           : (slot_q == SLOT_W'(FLP_SLOTS - 1));
        case (state_q)
            IDLE: begin
                scnt_d = scnt_q;
                if (tx_busy) begin
                    pcnt_d = '0;
                end else if (pcnt_q == PW'(PERIOD_CYC - 1)) begin
                    state_d  = PULSE;
                    pcnt_d   = '0;
                    slot_d   = '0;
                    scnt_d   = '0;
                    mode_d   = link_mode_t'(mode);
                    lcw_d    = lcw;
                    active_d = 1'b1;
                    trig_c   = 1'b1;
                    en_c     = 1'b1;
                end
            end
            PULSE: begin
                if (scnt_q == SW'(PULSE_CYC - 1)) begin
                    if (last_slot_c) begin
                        state_d  = IDLE;
                        scnt_d   = '0;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (scnt_q == SW'(SLOT_CYC - 1)) begin
                    state_d = PULSE;
                    slot_d  = slot_nx_c;
                    scnt_d  = '0;
                    trig_c  = 1'b1;
                    // odd slots carry lcw bits LSB first; even slots are clocks
                    en_c    = slot_nx_c[0] ? lcw_q[slot_nx_c[4:1]] : 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    eth_pulse_gen #(
        .PULSE_CYC(PULSE_CYC)
    ) u_pulse (
        .clk  (clk),
        .rst  (rst),
        .trig (trig_c),
        .en   (en_c),
        .pulse(link)
    );

endmodule

// File: tb/tb_eth_link_pulse.sv
// Scoreboard bench for eth_link_pulse: an event-time reference model queues the
// expected link/active/done per edge; a monitor pops and compares each cycle.
module tb_eth_link_pulse;

    localparam int PULSE  = 4;
    localparam int PERIOD = 400;
    localparam int SLOT   = 8;

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        tx_busy = 1'b0;
    logic [15:0] lcw = 16'h0000;
    logic        link, active, done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state: edge index, edge of last period reference, event time
    int          e = -1;
    int          ref_e = -PERIOD;
    int          t = 0;
    bit          m_in = 1'b0;
    bit          m_done = 1'b0;
    logic        m_mode = 1'b0;
    logic [15:0] m_lcw = 16'h0000;

    always #5 clk = ~clk;

    eth_link_pulse #(
        .PULSE_CYC (PULSE),
        .PERIOD_CYC(PERIOD),
        .SLOT_CYC  (SLOT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .lcw    (lcw),
        .tx_busy(tx_busy),
        .link   (link),
        .active (active),
        .done   (done)
    );

    // Reference model: events start PERIOD edges after the last start or the
    // last busy-in-idle edge; the waveform is derived from time-since-start.
    initial begin : model
        int   ev_len, n, off;
        logic lk;
        forever begin
            @(posedge clk);
            if (rst) begin
                e     = -1;
                ref_e = -PERIOD;
                m_in  = 1'b0;
                t     = 0;
            end else begin
                e++;
                m_done = 1'b0;
                ev_len = (m_mode ? 32 * SLOT : 0) + PULSE;
                if (m_in) begin
                    t++;
                    if (t == ev_len) begin
                        m_in   = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (tx_busy) begin
                    ref_e = e;
                end else if (e - ref_e == PERIOD) begin
                    m_in   = 1'b1;
                    t      = 0;
                    m_mode = mode;
                    m_lcw  = lcw;
                    ref_e  = e;
                end
                n   = t / SLOT;
                off = t % SLOT;
                lk  = m_in && (off < PULSE) && ((n % 2 == 0) || m_lcw[4'((n - 1) / 2)]);
                exp_q.push_back('{cyc: e, v: {lk, m_in, m_done}});
            end
        end
    end

    task automatic check_vec(input string nm, input int cyc, input logic [2:0] got,
                             input logic [2:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s cyc=%0d link/active/done got=%b expected=%b",
                         nm, cyc, got, want);
        end
    endtask

    // Monitor: all outputs must be 0 shortly after reset asserts (no clock needed).
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                check_vec("reset", e, {link, active, done}, 3'b000);
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check_vec("cycle", x.cyc, {link, active, done}, x.v);
            end
        end
    end

    // Return at the negedge just before edge k, so inputs set next are sampled at k.
    task automatic goto(input int k);
        while (e < k - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        // NLP free-run from reset
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        goto(1210);

        // FLP burst A5A5; lcw change at slot 10 only affects the next burst
        mode = 1'b1;
        lcw  = 16'hA5A5;
        do_reset();
        goto(80);
        lcw = 16'h5A5A;
        goto(700);

        // deferral: busy sampled high on edges 100..600
        mode = 1'b0;
        do_reset();
        goto(100);
        tx_busy = 1'b1;
        goto(601);
        tx_busy = 1'b0;
        goto(1010);

        // mode toggled mid-NLP: next event becomes FLP
        mode = 1'b0;
        do_reset();
        goto(2);
        mode = 1'b1;
        goto(670);

        // reset while slot 7 is driven high
        mode = 1'b1;
        lcw  = 16'($urandom) | 16'h0008;
        do_reset();
        goto(57);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        goto(300);

        // busy rising exactly on the event-start edge
        mode = 1'b0;
        do_reset();
        goto(400);
        tx_busy = 1'b1;
        goto(401);
        tx_busy = 1'b0;
        goto(810);

        // randomized mode/lcw/busy activity
        mode = 1'($urandom);
        lcw  = 16'($urandom);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            goto(e + 1 + int'($urandom_range(50, 500)));
            mode = 1'($urandom);
            lcw  = 16'($urandom);
            goto(e + 1 + int'($urandom_range(100, 700)));
            tx_busy = 1'b1;
            goto(e + 1 + int'($urandom_range(1, 40)));
            tx_busy = 1'b0;
        end
        goto(e + 500);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
